time_counter: RTL and testbench

// - Current-time generator: keeps 24-hour BCD time HH:MM and advances it once per minute from an

---
 rtl/alarm_clock_pkg.sv | 14 +
 rtl/bcd_digit_counter.sv | 32 +++
 rtl/time_counter.sv | 99 +++++++++
 tb/tb_time_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm-clock time path.
// BCD digit type, legal digit limits and the default minute prescale.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_MS_HR      = 4'd2;
  localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;
  localparam bcd_t MAX_MS_MIN     = 4'd5;
  localparam bcd_t MAX_BCD        = 4'd9;

  localparam int CLK_PER_MIN_DEFAULT = 15360;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit register with parallel load, increment and forced wrap.
// carry is combinational: high when an increment takes the digit back to 0.
module bcd_digit_counter
  import alarm_clock_pkg::*;
#(
  parameter bcd_t MAX_VAL = MAX_BCD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       wrap_to_zero,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc && (wrap_to_zero || (value == MAX_VAL));

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (carry) begin
      value <= '0;
    end else if (inc) begin
      value <= value + 4'd1;
    end
  end

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD HH:MM time generator advanced once per minute by a prescaler,
// with a validated parallel load path from the key controller.
module time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_PER_MIN = CLK_PER_MIN_DEFAULT,
  parameter int CNT_W       = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       one_minute,
  output logic       day_rollover,
  output logic       load_err
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_PER_MIN - 1);

  logic [CNT_W-1:0] presc;
  logic             term;
  logic             load_valid;
  logic             load_ok;
  logic             tick;
  logic             hr_wrap;
  logic             ls_min_carry;
  logic             ms_min_carry;
  logic             ls_hr_carry;
  logic             day_wrap;

  // Hours units may only reach 3 when the tens digit is 2.
  assign load_valid = (new_current_time_ms_hr  <= MAX_MS_HR) &&
                      (new_current_time_ls_hr  <= ((new_current_time_ms_hr == MAX_MS_HR) ?
                                                   MAX_LS_HR_AT_2 : MAX_BCD)) &&
                      (new_current_time_ms_min <= MAX_MS_MIN) &&
                      (new_current_time_ls_min <= MAX_BCD);

  assign term    = (presc == TERM_CNT);
  assign load_ok = load_new_c && load_valid;
  // A valid load on the terminal-count cycle swallows that tick.
  assign tick    = term && !load_ok;
  assign hr_wrap = (current_time_ms_hr == MAX_MS_HR) && (current_time_ls_hr == MAX_LS_HR_AT_2);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (load_ok || term) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  bcd_digit_counter #(.MAX_VAL(MAX_BCD)) u_ls_min (
    .clock(clock), .reset(reset), .inc(tick), .load(load_ok),
    .load_val(new_current_time_ls_min), .wrap_to_zero(1'b0),
    .value(current_time_ls_min), .carry(ls_min_carry)
  );

  bcd_digit_counter #(.MAX_VAL(MAX_MS_MIN)) u_ms_min (
    .clock(clock), .reset(reset), .inc(ls_min_carry), .load(load_ok),
    .load_val(new_current_time_ms_min), .wrap_to_zero(1'b0),
    .value(current_time_ms_min), .carry(ms_min_carry)
  );

  // Both hour digits are forced to 0 when the hour leaves 23.
  bcd_digit_counter #(.MAX_VAL(MAX_BCD)) u_ls_hr (
    .clock(clock), .reset(reset), .inc(ms_min_carry), .load(load_ok),
    .load_val(new_current_time_ls_hr), .wrap_to_zero(hr_wrap),
    .value(current_time_ls_hr), .carry(ls_hr_carry)
  );

  bcd_digit_counter #(.MAX_VAL(MAX_MS_HR)) u_ms_hr (
    .clock(clock), .reset(reset), .inc(ls_hr_carry), .load(load_ok),
    .load_val(new_current_time_ms_hr), .wrap_to_zero(hr_wrap),
    .value(current_time_ms_hr), .carry(day_wrap)
  );

  // Status pulses, registered alongside the digit update.
  always_ff @(posedge clock) begin
    if (reset) begin
      one_minute   <= 1'b0;
      day_rollover <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      one_minute   <= tick;
      day_rollover <= day_wrap;
      load_err     <= load_new_c && !load_valid;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed vector table, hand sequences and random
// stimulus, all compared against a minutes-of-day reference model.
module tb_time_counter;

  localparam int CPM = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic       one_minute, day_rollover, load_err;
  logic [18:0] dut_out;

  int checks = 0;
  int failures = 0;

  int m_tod = 0;
  int m_pc = 0;
  bit m_om = 0, m_dr = 0, m_le = 0;

  typedef struct {
    logic        r;
    logic        l;
    logic [15:0] nt;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[38];

  time_counter #(.CLK_PER_MIN(CPM), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .load_new_c(load_new_c),
    .new_current_time_ms_hr(n_mh), .new_current_time_ls_hr(n_lh),
    .new_current_time_ms_min(n_mm), .new_current_time_ls_min(n_lm),
    .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
    .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
    .one_minute(one_minute), .day_rollover(day_rollover), .load_err(load_err)
  );

  assign dut_out = {c_mh, c_lh, c_mm, c_lm, one_minute, day_rollover, load_err};

  always #5 clock = ~clock;

  function automatic vec_t mk(logic r, logic l, logic [15:0] nt, logic [15:0] t, logic [2:0] p);
    vec_t v;
    v.r = r; v.l = l; v.nt = nt; v.exp = {t, p};
    return v;
  endfunction

  function automatic bit legal(logic [15:0] nt);
    int h, m;
    h = int'(nt[15:12]) * 10 + int'(nt[11:8]);
    m = int'(nt[7:4]) * 10 + int'(nt[3:0]);
    return (nt[15:12] <= 2) && (nt[11:8] <= 9) && (nt[7:4] <= 5) && (nt[3:0] <= 9) && (h < 24) && (m < 60);
  endfunction

  function automatic logic [18:0] model_out();
    int hr, mn;
    hr = m_tod / 60;
    mn = m_tod % 60;
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), m_om, m_dr, m_le};
  endfunction

  task automatic model_step(input logic r, input logic l, input logic [15:0] nt);
    if (r) begin
      m_tod = 0; m_pc = 0; m_om = 0; m_dr = 0; m_le = 0;
    end else if (l && legal(nt)) begin
      m_tod = (int'(nt[15:12]) * 10 + int'(nt[11:8])) * 60 + int'(nt[7:4]) * 10 + int'(nt[3:0]);
      m_pc = 0; m_om = 0; m_dr = 0; m_le = 0;
    end else begin
      m_le = l;
      if (m_pc == CPM - 1) begin
        m_pc = 0;
        m_tod = (m_tod + 1) % 1440;
        m_om = 1;
        m_dr = (m_tod == 0);
      end else begin
        m_pc = m_pc + 1;
        m_om = 0;
        m_dr = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got time=%h pulses(om,dr,le)=%b required time=%h pulses=%b",
               name, $time, got[18:3], got[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic apply(input logic r, input logic l, input logic [15:0] nt, input string name);
    @(negedge clock);
    reset = r;
    load_new_c = l;
    {n_mh, n_lh, n_mm, n_lm} = nt;
    @(posedge clock);
    model_step(r, l, nt);
    #1;
    check(name, dut_out, model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 16'h0000, "idle");
  endtask

  initial begin
    // reset, then first tick after CPM idle cycles
    tbl[0]  = mk(1, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[2]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[3]  = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[4]  = mk(0, 0, 16'h0000, 16'h0001, 3'b100);
    tbl[5]  = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    // 12:59 -> 13:00
    tbl[6]  = mk(0, 1, 16'h1259, 16'h1259, 3'b000);
    tbl[7]  = mk(0, 0, 16'h0000, 16'h1259, 3'b000);
    tbl[8]  = mk(0, 0, 16'h0000, 16'h1259, 3'b000);
    tbl[9]  = mk(0, 0, 16'h0000, 16'h1259, 3'b000);
    tbl[10] = mk(0, 0, 16'h0000, 16'h1300, 3'b100);
    // 23:59 -> 00:00 with day_rollover
    tbl[11] = mk(0, 1, 16'h2359, 16'h2359, 3'b000);
    tbl[12] = mk(0, 0, 16'h0000, 16'h2359, 3'b000);
    tbl[13] = mk(0, 0, 16'h0000, 16'h2359, 3'b000);
    tbl[14] = mk(0, 0, 16'h0000, 16'h2359, 3'b000);
    tbl[15] = mk(0, 0, 16'h0000, 16'h0000, 3'b110);
    // rejected loads keep counting
    tbl[16] = mk(0, 1, 16'h2400, 16'h0000, 3'b001);
    tbl[17] = mk(0, 1, 16'h0960, 16'h0000, 3'b001);
    tbl[18] = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[19] = mk(0, 0, 16'h0000, 16'h0001, 3'b100);
    tbl[20] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    tbl[21] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    tbl[22] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    // valid load on the terminal-count cycle
    tbl[23] = mk(0, 1, 16'h0730, 16'h0730, 3'b000);
    tbl[24] = mk(0, 0, 16'h0000, 16'h0730, 3'b000);
    tbl[25] = mk(0, 0, 16'h0000, 16'h0730, 3'b000);
    tbl[26] = mk(0, 0, 16'h0000, 16'h0730, 3'b000);
    tbl[27] = mk(0, 0, 16'h0000, 16'h0731, 3'b100);
    // reset concurrent with load
    tbl[28] = mk(1, 1, 16'h1545, 16'h0000, 3'b000);
    tbl[29] = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[30] = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[31] = mk(0, 0, 16'h0000, 16'h0000, 3'b000);
    tbl[32] = mk(0, 0, 16'h0000, 16'h0001, 3'b100);
    // invalid load on the terminal-count cycle: tick still happens
    tbl[33] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    tbl[34] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    tbl[35] = mk(0, 0, 16'h0000, 16'h0001, 3'b000);
    tbl[36] = mk(0, 1, 16'h0260, 16'h0002, 3'b101);
    tbl[37] = mk(0, 0, 16'h0000, 16'h0002, 3'b000);

    for (int i = 0; i < 38; i++) begin
      apply(tbl[i].r, tbl[i].l, tbl[i].nt, "model_tbl");
      check($sformatf("vec%0d", i), dut_out, tbl[i].exp);
    end

    // hours-units carry into hours-tens
    apply(1'b0, 1'b1, 16'h0959, "load_0959");
    idle(4);
    check("carry_0959", dut_out, {16'h1000, 3'b100});
    apply(1'b0, 1'b1, 16'h1959, "load_1959");
    idle(4);
    check("carry_1959", dut_out, {16'h2000, 3'b100});

    // load held several cycles keeps the prescaler at 0
    apply(1'b0, 1'b1, 16'h1111, "hold1");
    apply(1'b0, 1'b1, 16'h1111, "hold2");
    apply(1'b0, 1'b1, 16'h1111, "hold3");
    idle(3);
    check("hold_no_tick", dut_out, {16'h1111, 3'b000});
    idle(1);
    check("hold_tick", dut_out, {16'h1112, 3'b100});

    // reset mid-count
    idle(2);
    apply(1'b1, 1'b0, 16'h0000, "mid_reset");
    check("mid_reset_const", dut_out, {16'h0000, 3'b000});

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, l;
      logic [15:0] nt;
      logic [3:0]  mh;
      r = ($urandom_range(63) == 0);
      l = ($urandom_range(3) == 0);
      if ($urandom_range(1) == 1) begin
        mh = 4'($urandom_range(2));
        nt = {mh, 4'((mh == 4'd2) ? $urandom_range(3) : $urandom_range(9)),
              4'($urandom_range(5)), 4'($urandom_range(9))};
      end else begin
        nt = 16'($urandom);
      end
      apply(r, l, nt, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
